uart_tx_fifo: RTL and testbench

Byte queue and launch controller between the host write side and the UART transmitter. It buffers up to DEPTH bytes, then presents them one at a time on `tx_start`/`tx_data`, using the transmitter's `tx_busy` as the handshake. It sits directly upstream of the transmitter, so the host can burst bytes without waiting on the baud rate.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_sync_fifo.sv | 75 +++++++
 rtl/uart_tx_fifo.sv | 87 ++++++++
 tb/tb_uart_tx_fifo.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Holds the launch FSM state encoding and the default data width.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    SEND
  } uart_txq_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Circular byte buffer with tracked occupancy, flush and overflow pulse.
// Full and empty are registered alongside count so all three move together.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = UART_DATA_W,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             flush,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow
);

  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_d;
  logic             push;
  logic             pop;

  // full is the registered state, so a same-cycle pop never frees a slot
  assign push = wr_en && !full && !flush;
  assign pop  = rd_en && !empty && !flush;

  always_comb begin
    count_d = count;
    unique case (1'b1)
      flush:         count_d = '0;
      push && !pop:  count_d = count + 1'b1;
      pop && !push:  count_d = count - 1'b1;
      default:       count_d = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      count    <= count_d;
      full     <= (count_d == CNT_MAX);
      empty    <= (count_d == '0);
      overflow <= wr_en && full && !flush;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue plus launch controller feeding the UART transmitter.
// tx_start is a level request held until tx_busy shows acceptance.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = UART_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [WIDTH-1:0]       tx_data
);

  uart_txq_state_t  state;
  uart_txq_state_t  state_d;
  logic             rd_en;
  logic             start_d;
  logic [WIDTH-1:0] rd_data;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .flush    (flush),
    .rd_data  (rd_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always_comb begin
    state_d = state;
    rd_en   = 1'b0;
    start_d = tx_start;
    unique case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          rd_en   = 1'b1;
          start_d = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (tx_busy) begin
          start_d = 1'b0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: begin
        start_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // tx_data is only reloaded on a pop, so flush leaves an in-flight byte intact
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      state    <= state_d;
      tx_start <= start_d;
      if (rd_en) tx_data <= rd_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a behavioural transmitter model.
// Stimulus queues expected bytes; a monitor checks each launch in order.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;

  logic       model_busy;
  logic       man_mode;
  logic       man_busy;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  assign tx_busy = man_mode ? man_busy : model_busy;

  always #5 clk = ~clk;

  uart_tx_fifo dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // transmitter: busy 3 cycles after tx_start, for 10 cycles
  initial begin
    int dly;
    int bc;
    model_busy = 1'b0;
    dly = 0;
    bc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset || man_mode) begin
        model_busy = 1'b0;
        dly = 0;
        bc = 0;
      end else if (model_busy) begin
        bc++;
        if (bc >= 10) begin
          model_busy = 1'b0;
          bc = 0;
        end
      end else if (tx_start) begin
        dly++;
        if (dly >= 3) begin
          model_busy = 1'b1;
          dly = 0;
        end
      end
    end
  end

  // monitor: every new launch must match the head of the scoreboard
  initial begin
    logic       prev_start;
    logic [7:0] held;
    prev_start = 1'b0;
    held = 8'h00;
    forever begin
      @(negedge clk);
      if (reset && tx_start) begin
        if (!prev_start) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_launch: got 0x%0h expected none",
                     tx_data);
          end else begin
            chk("launch_data", tx_data, exp_q.pop_front());
          end
        end else begin
          chk("tx_data_stable", tx_data, held);
        end
      end
      prev_start = tx_start;
      held = tx_data;
    end
  end

  task automatic push(input logic [7:0] d, input bit expect_tx);
    wr_en = 1'b1;
    wr_data = d;
    if (expect_tx) exp_q.push_back(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(string name);
    int n;
    n = 0;
    while (n < 1000 &&
           !(exp_q.size() == 0 && empty && !tx_start && !tx_busy)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 1000) begin
      failures++;
      $display("FAIL %s_timeout: got %0d cycles expected <1000", name, n);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    wr_en = 1'b0;
    wr_data = 8'h00;
    flush = 1'b0;
    man_mode = 1'b0;
    man_busy = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_full", full, 0);
    reset = 1'b1;
    @(negedge clk);

    // single byte
    push(8'h5A, 1'b1);
    chk("single_n1_start", tx_start, 0);
    chk("single_n1_count", count, 1);
    @(negedge clk);
    chk("single_n2_start", tx_start, 1);
    chk("single_n2_data", tx_data, 8'h5A);
    n = 0;
    while (!tx_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("single_busy_seen", tx_busy, 1);
    @(negedge clk);
    chk("single_start_drop", tx_start, 0);
    n = 0;
    while (tx_busy && n < 20) begin
      chk("single_empty_send", empty, 1);
      @(negedge clk);
      n++;
    end
    wait_drain("single");

    // burst to full, then overflow with transmitter held busy
    man_mode = 1'b1;
    man_busy = 1'b1;
    for (int i = 1; i <= 16; i++) push(8'(i), 1'b1);
    chk("burst_full", full, 1);
    chk("burst_count", count, 16);
    push(8'hFF, 1'b0);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", count, 16);
    @(negedge clk);
    chk("ovf_single", overflow, 0);
    chk("ovf_full", full, 1);
    man_mode = 1'b0;
    wait_drain("burst");

    // simultaneous push and pop at count 3
    man_mode = 1'b1;
    man_busy = 1'b1;
    push(8'hA1, 1'b1);
    push(8'hA2, 1'b1);
    push(8'hA3, 1'b1);
    chk("sim_pre_count", count, 3);
    man_busy = 1'b0;
    push(8'hA4, 1'b1);
    chk("sim_count", count, 3);
    chk("sim_launch", tx_start, 1);
    man_mode = 1'b0;
    wait_drain("simul");

    // pointer wrap
    for (int i = 0; i < 10; i++) push(8'h20 + 8'(i), 1'b1);
    wait_drain("wrap_a");
    for (int i = 10; i < 20; i++) push(8'h20 + 8'(i), 1'b1);
    wait_drain("wrap_b");

    // flush with one byte in flight
    push(8'hB0, 1'b1);
    for (int i = 1; i < 6; i++) push(8'hB0 + 8'(i), 1'b0);
    n = 0;
    while (!(tx_busy && !tx_start) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("flush_pre_count", count, 5);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    wait_drain("flush");
    repeat (40) @(negedge clk);

    // reset asserted while launching
    push(8'h77, 1'b1);
    n = 0;
    while (!tx_start && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("mid_launch_start", tx_start, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_start", tx_start, 0);
    chk("mid_rst_data", tx_data, 8'h00);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_ovf", overflow, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    chk("end_scoreboard_empty", exp_q.size(), 0);
    chk("end_idle", tx_start, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
